// File: rtl/hazard_pkg.sv
// Shared opcodes, forward-select encodings, scoreboard slot layout and halt FSM states
// for the WISC hazard/forwarding controller.
package hazard_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] FWD_REG = 3'b000;
  localparam logic [2:0] FWD_WB  = 3'b001;
  localparam logic [2:0] FWD_MEM = 3'b010;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [3:0] dst;
    logic       is_load;
    logic       is_hlt;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTING,
    ST_HALTED
  } hstate_e;

  // Youngest producer wins: the EX slot is checked before the MEM slot.
  function automatic logic [2:0] fwd_sel(input logic use_src, input logic [3:0] src,
                                         input slot_t ex, input slot_t mem);
    logic [2:0] sel;
    sel = FWD_REG;
    if (use_src) begin
      if (ex.valid && ex.wr && ex.dst == src)
        sel = FWD_MEM;
      else if (mem.valid && mem.wr && mem.dst == src)
        sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/instr_src_decode.sv
// Combinational decode of an ID instruction into its source registers, destination,
// and load/halt class.
module instr_src_decode
  import hazard_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic        useA,
  output logic        useB,
  output logic [3:0]  dst,
  output logic        wr,
  output logic        is_load,
  output logic        is_hlt
);

  logic [3:0] op;
  assign op  = instr[15:12];
  assign dst = instr[11:8];

  always_comb begin
    srcA    = instr[7:4];
    srcB    = instr[3:0];
    useA    = 1'b0;
    useB    = 1'b0;
    wr      = 1'b0;
    is_load = 1'b0;
    is_hlt  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: begin
        useA = 1'b1;
        useB = 1'b1;
        wr   = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        useA = 1'b1;
        wr   = 1'b1;
      end
      OP_LW: begin
        useA    = 1'b1;
        wr      = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        // Store data comes from the rd field.
        useA = 1'b1;
        useB = 1'b1;
        srcB = instr[11:8];
      end
      OP_LHB, OP_LLB: begin
        useA = 1'b1;
        srcA = instr[11:8];
        wr   = 1'b1;
      end
      OP_BR:  useA   = 1'b1;
      OP_PCS: wr     = 1'b1;
      OP_HLT: is_hlt = 1'b1;
      OP_B:   ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX/MEM/WB write scoreboard producing registered forward selects, load-use stall/bubble
// and HLT drain sequencing. Optional load-use stall counter under HAZ_STALL_CNT_EN.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_instr,
  input  logic        id_valid,
  input  logic        id_flush,
  input  logic        mem_stall,
  output logic [2:0]  ForwardA,
  output logic [2:0]  ForwardB,
  output logic        stall,
  output logic        bubble,
  output logic        halted
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  logic [3:0] srcA, srcB, dec_dst;
  logic       useA, useB, dec_wr, dec_is_load, dec_is_hlt;

  instr_src_decode u_dec (
    .instr   (id_instr),
    .srcA    (srcA),
    .srcB    (srcB),
    .useA    (useA),
    .useB    (useB),
    .dst     (dec_dst),
    .wr      (dec_wr),
    .is_load (dec_is_load),
    .is_hlt  (dec_is_hlt)
  );

  slot_t      ex_q, ex_d, mem_q, wb_q;
  logic [2:0] fa_q, fa_d, fb_q, fb_d;
  hstate_e    state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       adv, load_use, halt_blk, issue;

  assign adv      = ~mem_stall;
  assign halt_blk = (state_q != ST_RUN);
  assign load_use = id_valid & ~id_flush & ex_q.valid & ex_q.is_load &
                    ((useA & (srcA == ex_q.dst)) | (useB & (srcB == ex_q.dst)));
  assign stall    = load_use | halt_blk;
  assign bubble   = stall | id_flush;
  assign issue    = id_valid & ~id_flush & ~stall;
  assign halted   = (state_q == ST_HALTED);
  assign ForwardA = fa_q;
  assign ForwardB = fb_q;

  always_comb begin
    ex_d = SLOT_EMPTY;
    fa_d = FWD_REG;
    fb_d = FWD_REG;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.wr      = dec_wr;
      ex_d.dst     = dec_dst;
      ex_d.is_load = dec_is_load;
      ex_d.is_hlt  = dec_is_hlt;
      fa_d         = fwd_sel(useA, srcA, ex_q, mem_q);
      fb_d         = fwd_sel(useB, srcB, ex_q, mem_q);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (issue && dec_is_hlt) begin
          state_d = ST_HALTING;
          drain_d = 2'd3;
        end
      end
      ST_HALTING: begin
        drain_d = drain_q - 2'd1;
        if (drain_q == 2'd1)
          state_d = ST_HALTED;
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  // Everything in the scoreboard freezes together while data memory is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= SLOT_EMPTY;
      mem_q   <= SLOT_EMPTY;
      wb_q    <= SLOT_EMPTY;
      fa_q    <= FWD_REG;
      fb_q    <= FWD_REG;
      state_q <= ST_RUN;
      drain_q <= 2'd0;
    end else if (adv) begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // WB occupancy is tracked, but no decision reads it: its forward is taken from MEM pre-edge.
  logic unused_wb;
  assign unused_wb = ^wb_q;

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= 16'd0;
    else if (load_use && !halt_blk && adv && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
